vga_line_sched: RTL and testbench

VGA_LINE_SCHED -- requirements
Module: vga_line_sched

---
 rtl/vga_line_sched_pkg.sv | 19 +
 rtl/vga_line_sched_if.sv | 18 +
 rtl/vga_dl_fifo.sv | 59 +++++
 rtl/vga_line_sched.sv | 103 ++++++++++
 tb/tb_vga_line_sched.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_line_sched_pkg.sv
// Shared types and default sizing for the scanline-synchronised display-list scheduler.
package vga_line_sched_pkg;

  localparam int DEPTH_DEF  = 8;
  localparam int Y_W_DEF    = 10;
  localparam int WORD_W_DEF = 3;

  typedef enum logic {
    ST_IDLE,
    ST_ISSUE
  } state_e;

  typedef struct packed {
    logic [Y_W_DEF-1:0]    y;
    logic [WORD_W_DEF-1:0] word;
    logic [31:0]           data;
  } entry_t;

endpackage

// File: rtl/vga_line_sched_if.sv
// Display-list push channel: valid/ready handshake carrying one {line, word, data} entry.
interface vga_line_sched_if
  import vga_line_sched_pkg::*;
#(
  parameter int Y_W    = Y_W_DEF,
  parameter int WORD_W = WORD_W_DEF
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [Y_W-1:0]    cmd_y;
  logic [WORD_W-1:0] cmd_word;
  logic [31:0]       cmd_data;

  modport master (output cmd_valid, cmd_y, cmd_word, cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, cmd_y, cmd_word, cmd_data, output cmd_ready);

endinterface

// File: rtl/vga_dl_fifo.sv
// Synchronous display-list FIFO with occupancy count and a flush that overrides push/pop.
module vga_dl_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 45
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [W-1:0]           din_i,
  output logic [W-1:0]           dout_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q;
  logic          push_ok, pop_ok;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  // Fullness is judged before any same-cycle pop, so a push at DEPTH is refused.
  assign push_ok = push_i && !full_o && !flush_i;
  assign pop_ok  = pop_i && !empty_o && !flush_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/vga_line_sched.sv
// Replays queued video-memory writes during horizontal blank of their target scanline; CPU writes win.
module vga_line_sched
  import vga_line_sched_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int Y_W    = Y_W_DEF,
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  vga_line_sched_if.slave        cmd,
  input  logic                   flush,
  input  logic                   cpu_we,
  input  logic [WORD_W-1:0]      cpu_word,
  input  logic [31:0]            cpu_data,
  input  logic                   line_start,
  input  logic [Y_W-1:0]         line_y,
  output logic                   mem_we,
  output logic [WORD_W-1:0]      mem_word,
  output logic [31:0]            mem_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   irq,
  input  logic                   irq_clr
);

  localparam int LW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [Y_W-1:0]    y;
    logic [WORD_W-1:0] word;
    logic [31:0]       data;
  } dl_entry_t;

  dl_entry_t         push_ent, head;
  logic              full, empty, push, hit, pop, drain;
  state_e            state_q;
  logic [Y_W-1:0]    cur_line_q;
  logic              mem_we_q, irq_q;
  logic [WORD_W-1:0] mem_word_q;
  logic [31:0]       mem_data_q;

  assign push_ent      = '{y: cmd.cmd_y, word: cmd.cmd_word, data: cmd.cmd_data};
  assign cmd.cmd_ready = !full;
  assign push          = cmd.cmd_valid && !full && !flush;
  assign hit           = (state_q == ST_ISSUE) && !empty && (head.y == cur_line_q);
  assign pop           = hit && !cpu_we && !flush;
  // A coincident push keeps the list non-empty, so only a pop that truly empties it raises irq.
  assign drain         = pop && (level == LW'(1)) && !push;

  vga_dl_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(dl_entry_t))
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .push_i  (cmd.cmd_valid),
    .pop_i   (pop),
    .din_i   (push_ent),
    .dout_o  (head),
    .level_o (level),
    .full_o  (full),
    .empty_o (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cur_line_q <= '0;
      mem_we_q   <= 1'b0;
      mem_word_q <= '0;
      mem_data_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      if (flush) begin
        state_q <= ST_IDLE;
      end else if (line_start) begin
        state_q    <= ST_ISSUE;
        cur_line_q <= line_y;
      end else if (state_q == ST_ISSUE && (empty || head.y != cur_line_q)) begin
        state_q <= ST_IDLE;
      end

      mem_we_q <= cpu_we || pop;
      if (cpu_we) begin
        mem_word_q <= cpu_word;
        mem_data_q <= cpu_data;
      end else if (pop) begin
        mem_word_q <= head.word;
        mem_data_q <= head.data;
      end

      if (drain)        irq_q <= 1'b1;
      else if (irq_clr) irq_q <= 1'b0;
    end
  end

  assign mem_we   = mem_we_q;
  assign mem_word = mem_word_q;
  assign mem_data = mem_data_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_vga_line_sched.sv
// Scoreboard bench: a queue-level reference model predicts each memory write and its cycle.
module tb_vga_line_sched;
  import vga_line_sched_pkg::*;

  localparam int DEPTH = DEPTH_DEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush, cpu_we, line_start, irq_clr, mem_we, irq;
  logic [2:0]  cpu_word, mem_word;
  logic [31:0] cpu_data, mem_data;
  logic [9:0]  line_y;
  logic [3:0]  level;

  always #5 clk = ~clk;

  vga_line_sched_if #(.Y_W(Y_W_DEF), .WORD_W(WORD_W_DEF)) cmd_if ();

  vga_line_sched #(.DEPTH(DEPTH), .Y_W(Y_W_DEF), .WORD_W(WORD_W_DEF)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd        (cmd_if.slave),
    .flush      (flush),
    .cpu_we     (cpu_we),
    .cpu_word   (cpu_word),
    .cpu_data   (cpu_data),
    .line_start (line_start),
    .line_y     (line_y),
    .mem_we     (mem_we),
    .mem_word   (mem_word),
    .mem_data   (mem_data),
    .level      (level),
    .irq        (irq),
    .irq_clr    (irq_clr)
  );

  typedef struct {
    logic [2:0]  word;
    logic [31:0] data;
    int unsigned cyc;
  } exp_t;

  exp_t        exp_q[$];
  entry_t      m_q[$];
  bit          m_active;
  logic [9:0]  m_cur;
  bit          m_irq;
  int unsigned cyc;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    exp_q.delete();
    m_active = 0;
    m_cur    = '0;
    m_irq    = 0;
  endtask

  // Reference rules: CPU write wins; otherwise an armed line writes its matching head entries in order.
  task automatic model_step();
    bit     pop_m;
    bit     ready_m;
    entry_t e;
    ready_m = (m_q.size() < DEPTH);
    pop_m   = 0;
    if (cpu_we) begin
      exp_q.push_back('{cpu_word, cpu_data, cyc + 1});
    end else if (m_active && m_q.size() > 0 && m_q[0].y == m_cur && !flush) begin
      exp_q.push_back('{m_q[0].word, m_q[0].data, cyc + 1});
      pop_m = 1;
    end
    if (flush) m_active = 0;
    else if (line_start) begin
      m_active = 1;
      m_cur    = line_y;
    end else if (m_active && (m_q.size() == 0 || m_q[0].y != m_cur)) m_active = 0;
    if (flush) m_q.delete();
    else begin
      if (pop_m) e = m_q.pop_front();
      if (cmd_if.cmd_valid && ready_m)
        m_q.push_back('{cmd_if.cmd_y, cmd_if.cmd_word, cmd_if.cmd_data});
    end
    if (pop_m && m_q.size() == 0) m_irq = 1;
    else if (irq_clr) m_irq = 0;
  endtask

  task automatic idle();
    cmd_if.cmd_valid = 0;
    cmd_if.cmd_y     = '0;
    cmd_if.cmd_word  = '0;
    cmd_if.cmd_data  = '0;
    flush      = 0;
    cpu_we     = 0;
    cpu_word   = '0;
    cpu_data   = '0;
    line_start = 0;
    line_y     = '0;
    irq_clr    = 0;
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
    idle();
  endtask

  task automatic push(input logic [9:0] y, input logic [2:0] w, input logic [31:0] d);
    cmd_if.cmd_valid = 1;
    cmd_if.cmd_y     = y;
    cmd_if.cmd_word  = w;
    cmd_if.cmd_data  = d;
    tick();
  endtask

  task automatic start_line(input logic [9:0] y);
    line_start = 1;
    line_y     = y;
    tick();
  endtask

  initial begin : monitor
    exp_t e;
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (rst_n) begin
        if (mem_we) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write actual word=%0h data=%0h required no write (cycle %0d)",
                     mem_word, mem_data, cyc);
          end else begin
            e = exp_q.pop_front();
            check("write_word", mem_word, e.word);
            check("write_data", mem_data, e.data);
            check("write_cycle", cyc, e.cyc);
          end
        end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
          checks++;
          errors++;
          $display("FAIL missing_write actual none required word=%0h data=%0h (cycle %0d)",
                   exp_q[0].word, exp_q[0].data, cyc);
          e = exp_q.pop_front();
        end
        check("level", level, m_q.size());
        check("cmd_ready", cmd_if.cmd_ready, (m_q.size() < DEPTH));
        check("irq", irq, m_irq);
      end
    end
  end

  initial begin : stimulus
    idle();
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_level", level, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_irq", irq, 0);
    check("rst_ready", cmd_if.cmd_ready, 1);
    rst_n = 1;

    // Two entries on line 5 drain back-to-back; the line-6 entry waits for its own line.
    push(10'd5, 3'd0, 32'hAAAA5555);
    push(10'd5, 3'd1, 32'h12345678);
    push(10'd6, 3'd2, 32'hFFFF0000);
    start_line(10'd5);
    repeat (4) tick();
    check("y5_level", level, 1);
    start_line(10'd6);
    repeat (3) tick();
    check("y6_irq", irq, 1);
    irq_clr = 1;
    tick();

    // CPU writes held for two cycles pre-empt the engine.
    push(10'd3, 3'd4, 32'h0000_0044);
    push(10'd3, 3'd5, 32'h0000_0055);
    line_start = 1; line_y = 10'd3; cpu_we = 1; cpu_word = 3'd7; cpu_data = 32'hDEADBEEF;
    tick();
    cpu_we = 1; cpu_word = 3'd7; cpu_data = 32'hDEADBEEF;
    tick();
    repeat (4) tick();
    irq_clr = 1;
    tick();

    // Full FIFO refuses pushes, including one coincident with a pop.
    for (int i = 0; i < DEPTH; i++) push(10'd1, 3'(i), 32'h1000_0000 + 32'(i));
    check("full_ready", cmd_if.cmd_ready, 0);
    push(10'd1, 3'd0, 32'hBAD0_0009);
    check("full_level", level, 8);
    start_line(10'd1);
    push(10'd1, 3'd1, 32'hBAD0_000A);
    check("push_pop_full_level", level, 7);
    repeat (10) tick();
    irq_clr = 1;
    tick();

    // Mismatched line leaves the head in place.
    push(10'd2, 3'd3, 32'h2222_3333);
    start_line(10'd1);
    repeat (3) tick();
    check("mismatch_level", level, 1);
    start_line(10'd2);
    repeat (3) tick();
    check("match_level", level, 0);
    irq_clr = 1;
    tick();
    check("irq_cleared", irq, 0);

    // Flush with a coincident push empties everything and never raises irq.
    for (int i = 0; i < 4; i++) push(10'd9, 3'(i), 32'h9000_0000 + 32'(i));
    flush = 1;
    cmd_if.cmd_valid = 1; cmd_if.cmd_y = 10'd9; cmd_if.cmd_data = 32'h9999_9999;
    tick();
    check("flush_level", level, 0);
    check("flush_irq", irq, 0);
    start_line(10'd9);
    repeat (3) tick();

    // Clear coincident with the draining pop: set wins.
    push(10'd7, 3'd1, 32'h7777_0001);
    start_line(10'd7);
    irq_clr = 1;
    tick();
    check("irq_set_beats_clr", irq, 1);
    irq_clr = 1;
    tick();

    // Asynchronous reset in the middle of an issue burst.
    push(10'd4, 3'd0, 32'h4444_0000);
    push(10'd4, 3'd1, 32'h4444_0001);
    push(10'd4, 3'd2, 32'h4444_0002);
    start_line(10'd4);
    #2;
    rst_n = 0;
    model_reset();
    #1;
    check("async_rst_level", level, 0);
    check("async_rst_mem_we", mem_we, 0);
    check("async_rst_mem_word", mem_word, 0);
    check("async_rst_mem_data", mem_data, 0);
    check("async_rst_ready", cmd_if.cmd_ready, 1);
    check("async_rst_irq", irq, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    push(10'd4, 3'd5, 32'h4444_0005);
    start_line(10'd4);
    repeat (3) tick();

    for (int n = 0; n < 1500; n++) begin
      cmd_if.cmd_valid = 1'($urandom_range(0, 1));
      cmd_if.cmd_y     = 10'($urandom_range(0, 3));
      cmd_if.cmd_word  = 3'($urandom_range(0, 7));
      cmd_if.cmd_data  = $urandom;
      flush      = ($urandom_range(0, 49) == 0);
      cpu_we     = ($urandom_range(0, 4) == 0);
      cpu_word   = 3'($urandom_range(0, 7));
      cpu_data   = $urandom;
      line_start = ($urandom_range(0, 7) == 0);
      line_y     = 10'($urandom_range(0, 3));
      irq_clr    = ($urandom_range(0, 9) == 0);
      tick();
    end
    repeat (4) tick();
    check("final_no_pending_writes", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
